// File: rtl/ahb_master_burst.sv
// AHB-Lite burst master: turns a start/addr/len command into a SINGLE or INCR
// burst, overlapping each beat's address phase with the previous beat's data phase.
module ahb_master_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  localparam int LEN_W    = $clog2(MAX_BURST)
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              start,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_rd,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hreadyout,
  input  logic              hresp
);
  localparam int BYTES = DATA_W / 8;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d, next_addr;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    issue_cnt_q, issue_cnt_d;
  logic [LEN_W:0]    data_cnt_q, data_cnt_d;
  logic [LEN_W:0]    last_beat;

  assign last_beat = {1'b0, len_q};
  assign hsize     = 3'($clog2(BYTES));
  assign wdata_rd  = busy_q & hwrite_q & (htrans_q != TR_IDLE) & hreadyout;

  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    cmd_wr_d      = cmd_wr_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    data_cnt_d    = data_cnt_q;
    next_addr     = haddr_q + ADDR_W'(BYTES);

    case (state_q)
      S_IDLE: begin
        hwdata_d = '0;
        if (start) begin
          state_d     = S_ADDR;
          haddr_d     = cmd_addr & ~ADDR_W'(BYTES - 1);
          htrans_d    = TR_NONSEQ;
          hwrite_d    = cmd_wr;
          hburst_d    = (cmd_len == '0) ? 3'b000 : 3'b001;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          cmd_wr_d    = cmd_wr;
          len_d       = cmd_len;
          issue_cnt_d = '0;
          data_cnt_d  = '0;
        end
      end
      default: begin
        if (hreadyout) begin
          // PIPE and LAST both carry a data phase that completes on this edge.
          if (state_q != S_ADDR) begin
            data_cnt_d = data_cnt_q + 1'b1;
            if (hresp) err_d = 1'b1;
            if (!cmd_wr_q) begin
              rdata_d       = hrdata;
              rdata_valid_d = 1'b1;
            end
          end
          if (state_q == S_LAST) begin
            if (data_cnt_q == last_beat) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (issue_cnt_q == last_beat) begin
            state_d  = S_LAST;
            haddr_d  = '0;
            htrans_d = TR_IDLE;
            hwrite_d = 1'b0;
            hburst_d = 3'b000;
          end else begin
            state_d     = S_PIPE;
            issue_cnt_d = issue_cnt_q + 1'b1;
            haddr_d     = next_addr;
            // A 1 KB crossing must restart the burst with NONSEQ.
            htrans_d    = (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
          end
        end
      end
    endcase

    if (wdata_rd) hwdata_d = wdata;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q       <= S_IDLE;
      haddr_q       <= '0;
      htrans_q      <= TR_IDLE;
      hwrite_q      <= 1'b0;
      hburst_q      <= 3'b000;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cmd_wr_q      <= 1'b0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      data_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cmd_wr_q      <= cmd_wr_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      data_cnt_q    <= data_cnt_d;
    end
  end

  assign haddr       = haddr_q;
  assign htrans      = htrans_q;
  assign hwrite      = hwrite_q;
  assign hburst      = hburst_q;
  assign hwdata      = hwdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: doc/ahb_master_burst.md
Name: ahb_master_burst

Overview:
Parametrised AHB-Lite bus master with a command-driven front end. It issues single transfers or incrementing bursts of up to MAX_BURST beats, with the address phase of beat k overlapped with the data phase of beat k-1. It sits between the top-level controller and the decoder/slave mux. It replaces the single-beat master's idle/control/write/read flow with real pipelining, HTRANS/HBURST/HSIZE signalling, error reporting and 1 KB boundary handling.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; 32 or 64 only.
MAX_BURST, 16, maximum beats per command; a power of 2 no greater than 256.
LEN_W, $clog2(MAX_BURST), derived localparam; width of cmd_len.

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
start  in  1  command strobe; accepted only when busy=0
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start address; must be aligned to DATA_W/8
cmd_len  in  LEN_W  number of beats minus 1
wdata  in  DATA_W  write data (FWFT source); must be valid whenever wdata_rd can assert
wdata_rd  out  1  combinational pop strobe for wdata
rdata  out  DATA_W  read data beat
rdata_valid  out  1  1-cycle pulse per read beat
busy  out  1  command in progress
done  out  1  1-cycle pulse at command end
err  out  1  sticky; cleared on next accepted start
haddr  out  ADDR_W  AHB address
htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY never driven)
hwrite  out  1  AHB write
hsize  out  3  constant $clog2(DATA_W/8)
hburst  out  3  SINGLE=000 when cmd_len=0, otherwise INCR=001
hwdata  out  DATA_W  AHB write data
hrdata  in  DATA_W  read data from the slave mux
hreadyout  in  1  transfer-complete signal from the slave mux
hresp  in  1  1 = ERROR

Behaviour:
- Reset (async, hresetn=0): every output except wdata_rd and hsize is 0. htrans=IDLE. hsize keeps its constant value. Any burst in progress is abandoned with no done pulse.
- All outputs are registered, except wdata_rd (combinational) and hsize (constant).
- FSM states:
  - IDLE: stays here until start=1.
  - ADDR: only address phases outstanding (first beat).
  - PIPE: address phase and data phase overlapped.
  - LAST: data phase of the final beat only.
- Transitions:
  - IDLE->ADDR on start. At that edge: capture the command; haddr=cmd_addr, htrans=NONSEQ, hwrite=cmd_wr, hburst set from cmd_len, busy=1, err=0.
  - ADDR/PIPE: an address phase completes at an edge where hreadyout=1.
    - If beats remain to issue: haddr += DATA_W/8 and state becomes PIPE. htrans=SEQ, or NONSEQ if the new address crosses a 1 KB boundary (haddr[9:0] wraps to 0).
    - If no beats remain: htrans=IDLE, haddr=0, hwrite=0, state becomes LAST.
  - cmd_len=0 goes ADDR->LAST directly.
  - LAST->IDLE at the edge where hreadyout=1. At that edge: done=1 (for 1 cycle), busy=0.
- hreadyout=0 stalls both phases. haddr, htrans, hwrite and hwdata hold their values; no counter moves.
- Write data: wdata_rd = busy & hwrite & (htrans!=IDLE) & hreadyout. At that same edge hwdata<=wdata. hwdata holds until the next pop; it returns to 0 one cycle after done.
- Read data: at each edge where a read data phase completes (hreadyout=1 in PIPE/LAST), rdata<=hrdata and rdata_valid=1 for the following cycle. rdata holds its value between beats.
- Error: any edge with hresp=1 & hreadyout=1 during a data phase sets err.
  - The burst continues to completion. Read beats still pulse rdata_valid.
  - err stays high after done until the next start.
- Counters: issue_cnt and data_cnt, each LEN_W+1 bits. Exactly cmd_len+1 address phases and cmd_len+1 data phases are performed per command.
- start while busy=1: ignored, with no side effect. start in the done cycle is accepted, because busy is already 0.
- Unaligned cmd_addr: the low bits are forced to 0.

Test Plan:
1. Single write: cmd_addr=0x100, cmd_wr=1, cmd_len=0, wdata=0xA5A5A5A5, hreadyout=1 -> htrans=NONSEQ/hburst=SINGLE for 1 cycle, then hwdata=0xA5A5A5A5; done pulses 2 cycles after start; err=0.
2. 4-beat read with a wait state: cmd_addr=0x200, cmd_len=3, slave holds hreadyout=0 for 1 cycle on beat 2 -> haddr=0x200/204/208/20C with htrans NONSEQ,SEQ,SEQ,SEQ; haddr holds during the stall; 4 rdata_valid pulses carrying hrdata values in order.
3. 1 KB crossing: cmd_addr=0x3F8, cmd_len=3, write -> haddr 0x3F8(NONSEQ), 0x3FC(SEQ), 0x400(NONSEQ), 0x404(SEQ); wdata_rd pulses exactly 4 times.
4. Error: hresp=1 with hreadyout=1 on beat 1 of a 3-beat read -> err=1; burst still issues 3 beats; done pulses; err stays 1 until the next start, then clears.
5. Reset mid-burst: hresetn low during PIPE of an 8-beat write -> all outputs 0 immediately, htrans=IDLE, no done; a new command after reset runs normally.
6. Back-to-back/ignore: start held high during busy -> no effect; start asserted in the done cycle -> new NONSEQ on the next edge.
